// File: rtl/button_conditioner.sv
// Push-button front end: per-channel 2-FF synchronizer, counter debouncer and press-pulse generator.
// Define BTN_COND_HOLD_EN to build the per-channel long-press hold counters; otherwise hold_flag is tied low.
module button_conditioner #(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 100_000_000
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_db,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] hold_flag
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // The counter width only covers 0..DEBOUNCE_CYCLES-1, so tiny values would break it.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("button_conditioner: DEBOUNCE_CYCLES must be >= 2");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("button_conditioner: HOLD_CYCLES must be >= 1");
    end

    genvar gi;
    for (gi = 0; gi < N_BTN; gi++) begin : g_ch
        logic             sync1_q;
        logic             sync2_q;
        logic             db_q;
        logic             db_d;
        logic             pulse_q;
        logic             pulse_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;

        // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
        always_comb begin
            db_d  = db_q;
            cnt_d = '0;
            if (sync2_q != db_q) begin
                if (cnt_q == CNT_LAST) begin
                    db_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            pulse_d = db_q & ~db_d;
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
                db_q    <= 1'b1;
                cnt_q   <= '0;
                pulse_q <= 1'b0;
            end else begin
                sync1_q <= btn_raw[gi];
                sync2_q <= sync1_q;
                db_q    <= db_d;
                cnt_q   <= cnt_d;
                pulse_q <= pulse_d;
            end
        end

        assign btn_db[gi]      = db_q;
        assign press_pulse[gi] = pulse_q;

`ifdef BTN_COND_HOLD_EN
        localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
        localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

        logic [HOLD_W-1:0] hold_cnt_q;
        logic [HOLD_W-1:0] hold_cnt_d;
        logic              hold_q;
        logic              hold_d;

        // Count is based on the current level so the flag rises HOLD_CYCLES edges after the fall,
        // while the flag itself looks at the next level so it drops on the release edge.
        always_comb begin
            hold_cnt_d = '0;
            if (!db_q) begin
                hold_cnt_d = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);
            end
            hold_d = ~db_d & (hold_cnt_d == HOLD_MAX);
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                hold_cnt_q <= '0;
                hold_q     <= 1'b0;
            end else begin
                hold_cnt_q <= hold_cnt_d;
                hold_q     <= hold_d;
            end
        end

        assign hold_flag[gi] = hold_q;
`else
        assign hold_flag[gi] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with a history-window reference model.
// Honours BTN_COND_HOLD_EN the same way the design does.
module tb_button_conditioner;

    localparam int N = 3;
    localparam int D = 4;
    localparam int H = 10;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [N-1:0] btn_raw = 3'b111;
    logic [N-1:0] btn_db;
    logic [N-1:0] press_pulse;
    logic [N-1:0] hold_flag;

    int total = 0;
    int bad   = 0;

    // Reference model state: pin delay line, last D synchronized samples, accepted levels.
    logic [N-1:0] s1_m, s2_m, db_m, pulse_m, hold_m;
    logic [N-1:0] win_m [D];
    int           cyc;
    int           fall_cyc [N];

    button_conditioner #(
        .N_BTN          (N),
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .btn_raw    (btn_raw),
        .btn_db     (btn_db),
        .press_pulse(press_pulse),
        .hold_flag  (hold_flag)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        s1_m    = '1;
        s2_m    = '1;
        db_m    = '1;
        pulse_m = '0;
        hold_m  = '0;
        for (int k = 0; k < D; k++) win_m[k] = '1;
        cyc = 0;
        for (int c = 0; c < N; c++) fall_cyc[c] = 0;
    endtask

    // A level is accepted when the last D synchronized samples all disagree with it.
    task automatic model_edge();
        logic [N-1:0] s;
        bit           all_diff;
        s    = s2_m;
        s2_m = s1_m;
        s1_m = btn_raw;
        for (int k = D - 1; k > 0; k--) win_m[k] = win_m[k-1];
        win_m[0] = s;
        cyc++;
        pulse_m = '0;
        for (int c = 0; c < N; c++) begin
            all_diff = 1'b1;
            for (int k = 0; k < D; k++) if (win_m[k][c] == db_m[c]) all_diff = 1'b0;
            if (all_diff) begin
                db_m[c] = ~db_m[c];
                if (!db_m[c]) begin
                    pulse_m[c]  = 1'b1;
                    fall_cyc[c] = cyc;
                end
            end
`ifdef BTN_COND_HOLD_EN
            hold_m[c] = !db_m[c] && ((cyc - fall_cyc[c]) >= H);
`else
            hold_m[c] = 1'b0;
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rstn) model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        model_reset();
        rstn    = 1'b0;
        btn_raw = 3'b111;
        repeat (3) begin
            @(negedge clk);
            total++;
            if ({btn_db, press_pulse, hold_flag} !== {3'b111, 3'b000, 3'b000}) begin
                bad++;
                $display("FAIL reset_hold got db/pp/hf=%b/%b/%b required 111/000/000", btn_db, press_pulse, hold_flag);
            end
        end
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if ({btn_db, press_pulse, hold_flag} !== {3'b111, 3'b000, 3'b000}) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got db/pp/hf=%b/%b/%b required 111/000/000", i, btn_db, press_pulse, hold_flag);
            end
        end
        $display("reset: idle outputs checked for 13 cycles");
    endtask

    task automatic test_press();
        int lat;
        int npulse;
        btn_raw[0] = 1'b0;
        lat = -1;
        npulse = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            total++;
            if ({btn_db, press_pulse, hold_flag} !== {db_m, pulse_m, hold_m}) begin
                bad++;
                $display("FAIL press_model cyc=%0d got db/pp/hf=%b/%b/%b required %b/%b/%b", i, btn_db, press_pulse, hold_flag, db_m, pulse_m, hold_m);
            end
            if (press_pulse != 3'b000) npulse++;
            if (lat < 0 && btn_db[0] === 1'b0) begin
                lat = i;
                total++;
                if (press_pulse !== 3'b001) begin
                    bad++;
                    $display("FAIL press_pulse_val got %b required 001", press_pulse);
                end
            end
        end
        total++;
        if (lat != 6) begin bad++; $display("FAIL press_latency got %0d required 6", lat); end
        total++;
        if (npulse != 1) begin bad++; $display("FAIL press_pulse_count got %0d required 1", npulse); end
        $display("press ch0: latency=%0d pulses=%0d", lat, npulse);

        btn_raw[0] = 1'b1;
        lat = -1;
        npulse = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            total++;
            if ({btn_db, press_pulse, hold_flag} !== {db_m, pulse_m, hold_m}) begin
                bad++;
                $display("FAIL release_model cyc=%0d got db/pp/hf=%b/%b/%b required %b/%b/%b", i, btn_db, press_pulse, hold_flag, db_m, pulse_m, hold_m);
            end
            if (press_pulse != 3'b000) npulse++;
            if (lat < 0 && btn_db[0] === 1'b1) lat = i;
        end
        total++;
        if (lat != 6) begin bad++; $display("FAIL release_latency got %0d required 6", lat); end
        total++;
        if (npulse != 0) begin bad++; $display("FAIL release_pulse_count got %0d required 0", npulse); end
        $display("release ch0: latency=%0d pulses=%0d", lat, npulse);
    endtask

    task automatic test_bounce();
        int npulse;
        for (int rep = 0; rep < 5; rep++) begin
            for (int ph = 0; ph < 4; ph++) begin
                btn_raw[1] = (ph == 3);
                tick();
                total++;
                if ({btn_db, press_pulse} !== {3'b111, 3'b000}) begin
                    bad++;
                    $display("FAIL bounce_reject rep=%0d ph=%0d got db/pp=%b/%b required 111/000", rep, ph, btn_db, press_pulse);
                end
            end
        end
        btn_raw[1] = 1'b1;
        repeat (4) begin
            tick();
            total++;
            if ({btn_db, press_pulse} !== {3'b111, 3'b000}) begin
                bad++;
                $display("FAIL bounce_settle got db/pp=%b/%b required 111/000", btn_db, press_pulse);
            end
        end
        btn_raw[1] = 1'b0;
        npulse = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            total++;
            if ({btn_db, press_pulse, hold_flag} !== {db_m, pulse_m, hold_m}) begin
                bad++;
                $display("FAIL bounce_model cyc=%0d got db/pp/hf=%b/%b/%b required %b/%b/%b", i, btn_db, press_pulse, hold_flag, db_m, pulse_m, hold_m);
            end
            if (press_pulse == 3'b010) npulse++;
        end
        total++;
        if (btn_db !== 3'b101 || npulse != 1) begin
            bad++;
            $display("FAIL bounce_accept got db=%b pulses=%0d required db=101 pulses=1", btn_db, npulse);
        end
        $display("bounce ch1: rejected 5 bursts, accepted stable low with %0d pulse", npulse);
        btn_raw[1] = 1'b1;
        repeat (8) tick();
    endtask

    task automatic test_simul();
        int lat;
        int npulse;
        btn_raw = 3'b010;
        lat = -1;
        npulse = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            total++;
            if ({btn_db, press_pulse, hold_flag} !== {db_m, pulse_m, hold_m}) begin
                bad++;
                $display("FAIL simul_model cyc=%0d got db/pp/hf=%b/%b/%b required %b/%b/%b", i, btn_db, press_pulse, hold_flag, db_m, pulse_m, hold_m);
            end
            if (press_pulse != 3'b000) npulse++;
            if (lat < 0 && btn_db === 3'b010) begin
                lat = i;
                total++;
                if (press_pulse !== 3'b101) begin
                    bad++;
                    $display("FAIL simul_pulse got %b required 101", press_pulse);
                end
            end
        end
        total++;
        if (lat != 6 || npulse != 1) begin
            bad++;
            $display("FAIL simul_timing got latency=%0d pulses=%0d required 6/1", lat, npulse);
        end
        $display("simultaneous ch0+ch2: latency=%0d pulse cycles=%0d", lat, npulse);
        btn_raw = 3'b111;
        repeat (10) tick();
    endtask

    task automatic test_hold();
        int  t_fall;
        int  t_hold;
        int  hold_seen;
        logic prev_hold;
        t_fall = -1;
        t_hold = -1;
        hold_seen = 0;
        prev_hold = 1'b0;
        btn_raw[2] = 1'b0;
        for (int i = 1; i <= 45; i++) begin
            if (i == 31) btn_raw[2] = 1'b1;
            tick();
            total++;
            if ({btn_db, press_pulse, hold_flag} !== {db_m, pulse_m, hold_m}) begin
                bad++;
                $display("FAIL hold_model cyc=%0d got db/pp/hf=%b/%b/%b required %b/%b/%b", i, btn_db, press_pulse, hold_flag, db_m, pulse_m, hold_m);
            end
            if (hold_flag != 3'b000) hold_seen++;
            if (t_fall < 0 && btn_db[2] === 1'b0) t_fall = i;
            if (t_hold < 0 && hold_flag[2] === 1'b1) t_hold = i;
            if (i > 31 && t_fall > 0 && btn_db[2] === 1'b1 && prev_hold === 1'b1) begin
                total++;
                if (hold_flag[2] !== 1'b0) begin
                    bad++;
                    $display("FAIL hold_clear got hf2=%b required 0 on release edge", hold_flag[2]);
                end
            end
            prev_hold = hold_flag[2];
        end
`ifdef BTN_COND_HOLD_EN
        total++;
        if (t_fall < 0 || t_hold - t_fall != H) begin
            bad++;
            $display("FAIL hold_delay got fall=%0d rise=%0d required rise-fall=%0d", t_fall, t_hold, H);
        end
        total++;
        if (hold_flag !== 3'b000) begin bad++; $display("FAIL hold_final got %b required 000", hold_flag); end
`else
        total++;
        if (hold_seen != 0) begin bad++; $display("FAIL hold_disabled got %0d flagged cycles required 0", hold_seen); end
`endif
        $display("hold ch2: fall=%0d flag_rise=%0d flagged_cycles=%0d", t_fall, t_hold, hold_seen);
    endtask

    task automatic test_reset_mid();
        int lat;
        btn_raw = 3'b110;
        repeat (8) tick();
        btn_raw = 3'b101;
        repeat (4) tick();
        rstn = 1'b0;
        model_reset();
        #1;
        total++;
        if ({btn_db, press_pulse, hold_flag} !== {3'b111, 3'b000, 3'b000}) begin
            bad++;
            $display("FAIL reset_async got db/pp/hf=%b/%b/%b required 111/000/000", btn_db, press_pulse, hold_flag);
        end
        repeat (2) tick();
        total++;
        if ({btn_db, press_pulse, hold_flag} !== {3'b111, 3'b000, 3'b000}) begin
            bad++;
            $display("FAIL reset_held got db/pp/hf=%b/%b/%b required 111/000/000", btn_db, press_pulse, hold_flag);
        end
        rstn = 1'b1;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            total++;
            if ({btn_db, press_pulse, hold_flag} !== {db_m, pulse_m, hold_m}) begin
                bad++;
                $display("FAIL reset_mid_model cyc=%0d got db/pp/hf=%b/%b/%b required %b/%b/%b", i, btn_db, press_pulse, hold_flag, db_m, pulse_m, hold_m);
            end
            if (lat < 0 && btn_db[1] === 1'b0) begin
                lat = i;
                total++;
                if (press_pulse !== 3'b010) begin bad++; $display("FAIL reset_mid_pulse got %b required 010", press_pulse); end
            end
        end
        total++;
        if (lat != 6) begin bad++; $display("FAIL reset_mid_latency got %0d required 6", lat); end
        $display("reset mid-debounce ch1: re-accepted after %0d edges", lat);
        btn_raw = 3'b111;
        repeat (10) tick();
    endtask

    task automatic test_random();
        int      ph_div;
        int      errs;
        errs = 0;
        ph_div = 2;
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) ph_div = ($urandom_range(0, 1) == 0) ? 2 : 9;
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, ph_div - 1) == 0) btn_raw[c] = ~btn_raw[c];
            if (i == 700) begin
                rstn = 1'b0;
                model_reset();
                #1;
                total++;
                if ({btn_db, press_pulse, hold_flag} !== {3'b111, 3'b000, 3'b000}) begin
                    bad++;
                    errs++;
                    $display("FAIL random_reset got db/pp/hf=%b/%b/%b required 111/000/000", btn_db, press_pulse, hold_flag);
                end
                tick();
                rstn = 1'b1;
            end
            tick();
            total++;
            if ({btn_db, press_pulse, hold_flag} !== {db_m, pulse_m, hold_m}) begin
                bad++;
                errs++;
                if (errs < 20)
                    $display("FAIL random_model cyc=%0d raw=%b got db/pp/hf=%b/%b/%b required %b/%b/%b", i, btn_raw, btn_db, press_pulse, hold_flag, db_m, pulse_m, hold_m);
            end
        end
        $display("random: 1500 cycles compared against model, %0d disagreements", errs);
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_simul();
        test_hold();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
